// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : Instruction fetch stage ahead of the decoder. Owns the PC,
//             fetches words over a req/ack handshake, holds each instruction
//             valid until accepted, then steps the PC (seq/J/JR/BEQ/BNE).
//             A fetch that is not acknowledged within TIMEOUT cycles parks
//             the stage in a sticky FAULT state until reset.
//  Config   : IFETCH_ALIGN_CHECK_EN - when defined, a misaligned next PC
//             (only reachable through JR) faults instead of being rounded
//             down to a word boundary.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  // instruction memory side
  output logic [31:0] imemAddr,
  output logic        imemReq,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  // decoder side
  output logic [31:0] instr,
  output logic        instrValid,
  input  logic        instrAccept,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  // next-PC controls, meaningful only alongside instrAccept
  input  logic [1:0]  pcSrcCtrl,
  input  logic        bneCtrl,
  input  logic        aluZero,
  input  logic [25:0] jAddr,
  input  logic [31:0] imm,
  input  logic [31:0] jrTarget,
  // status
  output logic        fault
);

  // Counter wide enough to hold TIMEOUT-1; at least one bit for TIMEOUT=1.
  localparam int                 c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] c_SRC_SEQ = 2'd0;
  localparam logic [1:0] c_SRC_J   = 2'd1;
  localparam logic [1:0] c_SRC_JR  = 2'd2;
  localparam logic [1:0] c_SRC_BR  = 2'd3;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [31:0]        r_pc;
  logic [31:0]        r_instr;
  logic               r_req;
  logic               r_valid;
  logic               r_fault;

  logic [31:0]        w_pc_plus4;
  logic [31:0]        w_br_target;
  logic               w_taken;
  logic [31:0]        w_target;
  logic [31:0]        w_next_pc;
  logic               w_misalign;

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_br_target = w_pc_plus4 + (imm << 2);
  assign w_taken     = bneCtrl ? ~aluZero : aluZero;

  // Raw next-PC selection from the decoder's control outputs.
  always_comb begin
    w_target = w_pc_plus4;
    case (pcSrcCtrl)
      c_SRC_SEQ: w_target = w_pc_plus4;
      c_SRC_J:   w_target = {w_pc_plus4[31:28], jAddr, 2'b00};
      c_SRC_JR:  w_target = jrTarget;
      c_SRC_BR:  w_target = w_taken ? w_br_target : w_pc_plus4;
      default:   w_target = w_pc_plus4;
    endcase
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  // Keep the target as-is and flag a misaligned word address.
  assign w_next_pc  = w_target;
  assign w_misalign = |w_target[1:0];
`else
  // Round the target down to a word boundary; never faults.
  assign w_next_pc  = w_target & 32'hFFFF_FFFC;
  assign w_misalign = 1'b0;
`endif

  // Fetch/hold/fault sequencer with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
      r_cnt   <= '0;
      r_req   <= 1'b1;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imemAck) begin
            r_instr <= imemData;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= ST_HOLD;
          end else if (r_cnt == c_CNT_LAST) begin
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_fault <= 1'b1;
            r_state <= ST_FAULT;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (instrAccept) begin
            if (w_misalign) begin
              r_valid <= 1'b0;
              r_fault <= 1'b1;
              r_state <= ST_FAULT;
            end else begin
              r_pc    <= w_next_pc;
              r_valid <= 1'b0;
              r_req   <= 1'b1;
              r_cnt   <= '0;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_FAULT: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
          r_fault <= 1'b1;
        end
        default: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
          r_fault <= 1'b1;
          r_state <= ST_FAULT;
        end
      endcase
    end
  end

  assign imemAddr   = r_pc;
  assign imemReq    = r_req;
  assign instr      = r_instr;
  assign instrValid = r_valid;
  assign pc         = r_pc;
  assign pcPlus4    = w_pc_plus4;
  assign fault      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Self-checking bench for instr_fetch. Directed scenarios plus a
//             randomized run, checked against a transaction-level PC model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
  localparam int          c_TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imemAddr;
  logic        imemReq;
  logic        imemAck = 1'b0;
  logic [31:0] imemData = 32'h0;
  logic [31:0] instr;
  logic        instrValid;
  logic        instrAccept = 1'b0;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [1:0]  pcSrcCtrl = 2'd0;
  logic        bneCtrl = 1'b0;
  logic        aluZero = 1'b0;
  logic [25:0] jAddr = 26'h0;
  logic [31:0] imm = 32'h0;
  logic [31:0] jrTarget = 32'h0;
  logic        fault;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: the PC of the instruction in flight and the
  // last instruction word handed over by memory.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_fault;

  instr_fetch #(.RESET_PC(c_RESET_PC), .TIMEOUT(c_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .imemAddr(imemAddr), .imemReq(imemReq), .imemAck(imemAck), .imemData(imemData),
    .instr(instr), .instrValid(instrValid), .instrAccept(instrAccept),
    .pc(pc), .pcPlus4(pcPlus4),
    .pcSrcCtrl(pcSrcCtrl), .bneCtrl(bneCtrl), .aluZero(aluZero),
    .jAddr(jAddr), .imm(imm), .jrTarget(jrTarget),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Random control inputs that the design must ignore at this moment.
  task automatic noise_ctrl();
    pcSrcCtrl = 2'($urandom_range(0, 3));
    bneCtrl   = 1'($urandom_range(0, 1));
    aluZero   = 1'($urandom_range(0, 1));
    jAddr     = 26'($urandom);
    imm       = $urandom;
    jrTarget  = $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imemAck = 1'b1; imemData = $urandom;
    instrAccept = 1'b1;
    noise_ctrl();
    step();
    step();
    m_pc = c_RESET_PC; m_instr = 32'h0; m_fault = 1'b0;
    chk("rst_pc", pc, c_RESET_PC);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", 32'(instrValid), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_req", 32'(imemReq), 32'h1);
    reset = 1'b0;
    imemAck = 1'b0;
    instrAccept = 1'b0;
  endtask

  // Leave the memory silent for n_wait cycles, then acknowledge with data.
  task automatic do_fetch(input int n_wait, input logic [31:0] data);
    for (int i = 0; i < n_wait; i++) begin
      imemAck = 1'b0; imemData = $urandom;
      instrAccept = 1'($urandom_range(0, 1));
      noise_ctrl();
      step();
      chk("wait_req", 32'(imemReq), 32'h1);
      chk("wait_valid", 32'(instrValid), 32'h0);
      chk("wait_addr", imemAddr, m_pc);
    end
    imemAck = 1'b1; imemData = data; instrAccept = 1'b0;
    step();
    imemAck = 1'b0;
    m_instr = data;
    chk("fetch_instr", instr, m_instr);
    chk("fetch_valid", 32'(instrValid), 32'h1);
    chk("fetch_req", 32'(imemReq), 32'h0);
    chk("fetch_pc", pc, m_pc);
  endtask

  // Stall n_hold cycles in HOLD (stray acks ignored), then accept.
  task automatic do_accept(input int n_hold, input logic [1:0] src, input logic bne,
                           input logic z, input logic [25:0] ja, input logic [31:0] im,
                           input logic [31:0] jr);
    logic [31:0] pc4;
    logic [31:0] tgt;
    logic        taken;
    for (int i = 0; i < n_hold; i++) begin
      imemAck = 1'($urandom_range(0, 1)); imemData = $urandom;
      instrAccept = 1'b0;
      noise_ctrl();
      step();
      chk("hold_valid", 32'(instrValid), 32'h1);
      chk("hold_instr", instr, m_instr);
      chk("hold_pc", pc, m_pc);
    end
    imemAck = 1'b0;
    pcSrcCtrl = src; bneCtrl = bne; aluZero = z; jAddr = ja; imm = im; jrTarget = jr;
    instrAccept = 1'b1;
    pc4 = m_pc + 32'd4;
    chk("hold_pc4", pcPlus4, pc4);
    step();
    instrAccept = 1'b0;
    noise_ctrl();
    // Next PC straight from the branch/jump rules.
    taken = bne ? !z : z;
    case (src)
      2'd0: tgt = pc4;
      2'd1: tgt = {pc4[31:28], ja, 2'b00};
      2'd2: tgt = jr;
      default: tgt = taken ? pc4 + im * 32'd4 : pc4;
    endcase
`ifdef IFETCH_ALIGN_CHECK_EN
    if (tgt % 4 != 0) m_fault = 1'b1;
    else m_pc = tgt;
`else
    m_pc = tgt - (tgt % 4);
`endif
    chk("acc_pc", pc, m_pc);
    chk("acc_fault", 32'(fault), 32'(m_fault));
    chk("acc_req", 32'(imemReq), 32'(!m_fault));
    chk("acc_valid", 32'(instrValid), 32'h0);
  endtask

  initial begin
    m_pc = c_RESET_PC; m_instr = 32'h0; m_fault = 1'b0;

    // 1: reset, ack after two silent cycles
    do_reset();
    do_fetch(2, 32'h8C22_0004);
    chk("t1_addr", imemAddr, 32'h0);
    chk("t1_instr", instr, 32'h8C22_0004);

    // 2: pc=0x10, sequential
    do_accept(1, 2'd2, 1'b0, 1'b0, 26'h0, 32'h0, 32'h10);
    do_fetch(0, 32'h1111_1111);
    do_accept(0, 2'd0, 1'b0, 1'b0, 26'h0, 32'h0, 32'h0);
    chk("t2_pc", pc, 32'h14);
    chk("t2_req", 32'(imemReq), 32'h1);

    // 3: pc=0x10, jump
    do_fetch(1, 32'h2222_2222);
    do_accept(0, 2'd2, 1'b0, 1'b0, 26'h0, 32'h0, 32'h10);
    do_fetch(0, 32'h3333_3333);
    do_accept(2, 2'd1, 1'b0, 1'b0, 26'h000_0040, 32'h0, 32'h0);
    chk("t3_pc", pc, 32'h100);

    // 4: pc=0x10, BEQ taken backwards then BNE not taken
    do_fetch(0, 32'h4444_4444);
    do_accept(0, 2'd2, 1'b0, 1'b0, 26'h0, 32'h0, 32'h10);
    do_fetch(0, 32'h5555_5555);
    do_accept(0, 2'd3, 1'b0, 1'b1, 26'h0, 32'hFFFF_FFFE, 32'h0);
    chk("t4_beq", pc, 32'h0C);
    do_fetch(0, 32'h6666_6666);
    do_accept(0, 2'd2, 1'b0, 1'b0, 26'h0, 32'h0, 32'h10);
    do_fetch(0, 32'h7777_7777);
    do_accept(0, 2'd3, 1'b1, 1'b1, 26'h0, 32'hFFFF_FFFE, 32'h0);
    chk("t4_bne", pc, 32'h14);

    // Wrap boundary: pcPlus4 of 0xFFFFFFFC is 0
    do_fetch(0, 32'h0);
    do_accept(0, 2'd2, 1'b0, 1'b0, 26'h0, 32'h0, 32'hFFFF_FFFC);
    do_fetch(0, 32'h0);
    do_accept(0, 2'd0, 1'b0, 1'b0, 26'h0, 32'h0, 32'h0);
    chk("wrap_pc", pc, 32'h0);

    // Randomized transactions against the model
    for (int t = 0; t < 30; t++) begin
      logic [31:0] jr;
      do_fetch(int'($urandom_range(0, c_TIMEOUT - 1)), $urandom);
      jr = $urandom;
`ifdef IFETCH_ALIGN_CHECK_EN
      jr = jr & 32'hFFFF_FFFC;
`endif
      do_accept(int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                26'($urandom), $urandom, jr);
    end

    // 5: misaligned JR target
    do_fetch(0, 32'h8888_8888);
    do_accept(0, 2'd2, 1'b0, 1'b0, 26'h0, 32'h0, 32'h10);
    do_fetch(0, 32'h9999_9999);
    do_accept(0, 2'd2, 1'b0, 1'b0, 26'h0, 32'h0, 32'h203);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("t5_fault", 32'(fault), 32'h1);
    chk("t5_pc", pc, 32'h10);
`else
    chk("t5_pc", pc, 32'h200);
    chk("t5_fault", 32'(fault), 32'h0);
`endif

    // 6: timeout boundary, fault stickiness, reset during HOLD
    do_reset();
    for (int i = 0; i < c_TIMEOUT - 1; i++) begin
      noise_ctrl();
      step();
    end
    chk("to_edge_req", 32'(imemReq), 32'h1);
    chk("to_edge_fault", 32'(fault), 32'h0);
    step();
    chk("to_fault", 32'(fault), 32'h1);
    chk("to_req", 32'(imemReq), 32'h0);
    chk("to_valid", 32'(instrValid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      imemAck = 1'b1; imemData = $urandom; instrAccept = 1'b1;
      noise_ctrl();
      step();
      chk("sticky_fault", 32'(fault), 32'h1);
      chk("sticky_valid", 32'(instrValid), 32'h0);
      chk("sticky_pc", pc, c_RESET_PC);
    end
    imemAck = 1'b0; instrAccept = 1'b0;

    do_reset();
    do_fetch(0, 32'hAAAA_5555);
    do_accept(0, 2'd2, 1'b0, 1'b0, 26'h0, 32'h0, 32'h40);
    do_fetch(1, 32'h5555_AAAA);
    reset = 1'b1; instrAccept = 1'b1; imemAck = 1'b1; jrTarget = 32'h80; pcSrcCtrl = 2'd2;
    step();
    reset = 1'b0; instrAccept = 1'b0; imemAck = 1'b0;
    chk("midhold_valid", 32'(instrValid), 32'h0);
    chk("midhold_pc", pc, c_RESET_PC);
    chk("midhold_instr", instr, 32'h0);
    chk("midhold_req", 32'(imemReq), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
